// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset / lock acquisition sequencer with retry, timeout and loss counting
//
// Drives the clocking wizard reset, waits for lock, requires lock to stay
// stable for a programmable number of cycles, and only then releases the
// downstream reset. Lock acquisition is retried a bounded number of times
// before latching a sticky error.
//
// Ports:
//   sys_clk    in   single clock, all logic on its rising edge
//   sys_rst    in   synchronous active-high reset
//   pll_locked in   wizard locked flag, asynchronous to sys_clk
//   pll_rst    out  active-high reset to the clocking wizard
//   rst_out_n  out  active-low reset to downstream clock consumers
//   ready      out  clocks locked and stable (always equal to rst_out_n)
//   lock_err   out  sticky acquisition failure flag
//   retry_cnt  out  timeouts seen in the current acquisition
//   loss_cnt   out  saturating count of lock losses while running
//   state      out  current state encoding, debug only

module pll_rst_seq #(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int STABLE_CYC   = 64,
    parameter int MAX_RETRY    = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       rst_out_n,
    output logic       ready,
    output logic       lock_err,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // One counter is shared by every timed state, so it only needs to
    // cover the longest of the three intervals.
    localparam int CNT_MAX_A = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYC) ? CNT_MAX_A : STABLE_CYC;
    localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, sync2_q;
    logic             pll_rst_q;
    logic             run_q;
    logic             lock_err_q;
    logic             locked_s;

    // Only the second synchronizer stage is visible to the FSM.
    assign locked_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            ST_PLL_RST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end

            ST_WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == LOCK_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_PLL_RST;
                    end
                end
            end

            ST_STABLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Lock drop is tested first so it wins over the final
                // stable cycle; a glitch never counts as a retry.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_PLL_RST;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end

            ST_FAIL: begin
                // Terminal until sys_rst; pll_locked is ignored here.
            end

            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state and registered, so each one
    // moves on the same edge as the transition that causes it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_PLL_RST;
            cnt_q      <= '0;
            retry_q    <= 4'd0;
            loss_q     <= 8'd0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            pll_rst_q  <= 1'b1;
            run_q      <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            sync1_q    <= pll_locked;
            sync2_q    <= sync1_q;
            pll_rst_q  <= (state_d == ST_PLL_RST);
            run_q      <= (state_d == ST_RUN);
            lock_err_q <= (state_d == ST_FAIL);
        end
    end

    // ready and rst_out_n share one flop so they can never disagree.
    assign pll_rst   = pll_rst_q;
    assign rst_out_n = run_q;
    assign ready     = run_q;
    assign lock_err  = lock_err_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - self-checking bench for pll_rst_seq
module tb_pll_rst_seq;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_ST  = 8;
    localparam int P_MR  = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, rst_out_n, ready, lock_err;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    pll_rst_seq #(
        .PLL_RST_CYC (P_RST),
        .LOCK_TIMEOUT(P_TO),
        .STABLE_CYC  (P_ST),
        .MAX_RETRY   (P_MR)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .rst_out_n (rst_out_n),
        .ready     (ready),
        .lock_err  (lock_err),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt),
        .state     (state)
    );

    // Reference model: phase plus cycles completed in that phase.
    int m_phase, m_elapsed, m_retries, m_losses;
    bit m_hist[$];

    task automatic model_edge(input bit rst, input bit lk);
        bit ls;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_retries = 0; m_losses = 0;
            m_hist = {1'b0, 1'b0};
            return;
        end
        ls = m_hist.pop_front();
        m_hist.push_back(lk);
        case (m_phase)
            0: begin
                m_elapsed++;
                if (m_elapsed == P_RST) begin m_phase = 1; m_elapsed = 0; end
            end
            1: begin
                if (ls) begin
                    m_phase = 2; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == P_TO) begin
                        m_elapsed = 0;
                        if (m_retries == P_MR) m_phase = 4;
                        else begin m_retries++; m_phase = 0; end
                    end
                end
            end
            2: begin
                if (!ls) begin
                    m_phase = 1; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == P_ST) begin m_phase = 3; m_elapsed = 0; m_retries = 0; end
                end
            end
            3: begin
                if (!ls) begin
                    m_phase = 0; m_elapsed = 0;
                    if (m_losses < 255) m_losses++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_edge(sys_rst, pll_locked);
        @(negedge sys_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit rst; bit lk; int n;
        bit e_pll_rst; bit e_ready; bit e_err; int e_retry; int e_loss; int e_state;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, pulses, changes, d, hi;
        bit prev;
        logic [3:0] prev_retry;
        logic [18:0] act_v, exp_v;
        int flip_div;

        m_hist = {1'b0, 1'b0};
        m_phase = 0; m_elapsed = 0; m_retries = 0; m_losses = 0;

        // rst lk n | pll_rst ready err retry loss state
        vecs.push_back(vec_t'{1, 0, 2, 1, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 3, 1, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 1, 0, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{0, 0, 5, 0, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{0, 1, 2, 0, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{0, 1, 1, 0, 0, 0, 0, 0, 2});
        vecs.push_back(vec_t'{0, 1, 7, 0, 0, 0, 0, 0, 2});
        vecs.push_back(vec_t'{0, 1, 1, 0, 1, 0, 0, 0, 3});
        vecs.push_back(vec_t'{0, 0, 2, 0, 1, 0, 0, 0, 3});
        vecs.push_back(vec_t'{0, 0, 1, 1, 0, 0, 0, 1, 0});
        vecs.push_back(vec_t'{0, 0, 3, 1, 0, 0, 0, 1, 0});
        vecs.push_back(vec_t'{0, 0, 1, 0, 0, 0, 0, 1, 1});

        @(negedge sys_clk);
        foreach (vecs[i]) begin
            sys_rst = vecs[i].rst;
            pll_locked = vecs[i].lk;
            repeat (vecs[i].n) tick();
            check($sformatf("vec%0d.pll_rst", i), 32'(pll_rst), 32'(vecs[i].e_pll_rst));
            check($sformatf("vec%0d.ready", i), 32'(ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d.rst_out_n", i), 32'(rst_out_n), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d.lock_err", i), 32'(lock_err), 32'(vecs[i].e_err));
            check($sformatf("vec%0d.retry_cnt", i), 32'(retry_cnt), 32'(vecs[i].e_retry));
            check($sformatf("vec%0d.loss_cnt", i), 32'(loss_cnt), 32'(vecs[i].e_loss));
            check($sformatf("vec%0d.state", i), 32'(state), 32'(vecs[i].e_state));
        end

        // Exhausted retries: three pulses, then sticky error at 72 cycles.
        sys_rst = 1; pll_locked = 0; tick();
        sys_rst = 0;
        k = 0; pulses = 1; changes = 0; prev = pll_rst; prev_retry = retry_cnt;
        while (!lock_err && k < 200) begin
            tick(); k++;
            if (pll_rst && !prev) pulses++;
            prev = pll_rst;
            if (retry_cnt != prev_retry) changes++;
            prev_retry = retry_cnt;
        end
        check("fail_latency", 32'(k), 32'd72);
        check("fail_pulses", 32'(pulses), 32'd3);
        check("fail_retry_steps", 32'(changes), 32'd2);
        check("fail_retry_final", 32'(retry_cnt), 32'd2);
        pll_locked = 1;
        repeat (30) tick();
        check("fail_sticky_state", 32'(state), 32'd4);
        check("fail_sticky_err", 32'(lock_err), 32'd1);
        check("fail_sticky_ready", 32'(ready), 32'd0);
        check("fail_sticky_pll_rst", 32'(pll_rst), 32'd0);
        sys_rst = 1; tick(); sys_rst = 0;
        check("fail_rst_err", 32'(lock_err), 32'd0);
        check("fail_rst_pll_rst", 32'(pll_rst), 32'd1);
        check("fail_rst_state", 32'(state), 32'd0);
        check("fail_rst_retry", 32'(retry_cnt), 32'd0);
        k = 0;
        while (!ready && k < 100) begin tick(); k++; end
        check("restart_ready", 32'(ready), 32'd1);

        // Lock glitch coinciding with the last STABLE cycle.
        sys_rst = 1; pll_locked = 1; tick(); sys_rst = 0;
        k = 0;
        while (state != 3'd2 && k < 50) begin tick(); k++; end
        check("glitch_reach_stable", 32'(state), 32'd2);
        repeat (5) tick();
        pll_locked = 0; tick();
        pll_locked = 1; tick();
        check("glitch_still_stable", 32'(state), 32'd2);
        tick();
        check("glitch_back_wait", 32'(state), 32'd1);
        check("glitch_ready_low", 32'(ready), 32'd0);
        check("glitch_retry_same", 32'(retry_cnt), 32'd0);
        tick();
        check("glitch_restable", 32'(state), 32'd2);
        repeat (8) tick();
        check("glitch_run_ready", 32'(ready), 32'd1);

        // Repeated lock losses in RUN; loss counter saturates.
        for (int i = 0; i < 256; i++) begin
            pll_locked = 0;
            d = 0;
            while (rst_out_n && d < 10) begin tick(); d++; end
            if (i == 0) begin
                check("loss_edges", 32'(d), 32'd3);
                check("loss_first_cnt", 32'(loss_cnt), 32'd1);
                check("loss_ready_low", 32'(ready), 32'd0);
                hi = 0;
                while (pll_rst && hi < 20) begin hi++; tick(); end
                check("loss_pll_rst_len", 32'(hi), 32'd4);
            end
            pll_locked = 1;
            k = 0;
            while (!ready && k < 100) begin tick(); k++; end
            if (!ready) check($sformatf("loss%0d_relock", i), 32'(ready), 32'd1);
        end
        check("loss_saturated", 32'(loss_cnt), 32'd255);

        // Randomized run against the reference model.
        sys_rst = 1; pll_locked = 0; tick();
        flip_div = 16;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0: flip_div = 4;
                    1: flip_div = 16;
                    default: flip_div = 64;
                endcase
            end
            sys_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, flip_div - 1) == 0) pll_locked = ~pll_locked;
            tick();
            act_v = {pll_rst, rst_out_n, ready, lock_err, retry_cnt, loss_cnt, state};
            exp_v = {m_phase == 0, m_phase == 3, m_phase == 3, m_phase == 4,
                     4'(m_retries), 8'(m_losses), 3'(m_phase)};
            check($sformatf("rand%0d", c), 32'(act_v), 32'(exp_v));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
